// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: branch-controller PC load, imem request/response, decode handoff.
// Latency: none, wires only.
// Backpressure: carries imem_req_ready and instr_ready from the consumers back to the fetch unit.
interface fetch_unit_if;
  typedef logic [31:0] instruction_t;

  // Branch controller -> fetch
  logic [31:0]  pc_in;
  logic         pc_load;
  // Fetch <-> instruction memory
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  // Fetch -> decode
  instruction_t instr_out;
  logic [31:0]  instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  // Status
  logic         fetch_err;

  modport master (
    input  pc_in, pc_load, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_addr, instr_out, instr_pc, instr_valid, fetch_err
  );

  modport slave (
    output pc_in, pc_load, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_addr, instr_out, instr_pc, instr_valid, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one word read per loaded PC, fetched word handed to decode; one fetch in flight.
// Latency: request the cycle after a PC load; instruction valid the cycle after the memory response.
// Backpressure: request and address held until imem_req_ready; instruction held until instr_ready.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PC loads raise fetch_err and issue no request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic        drop_q, drop_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        err_q, err_d;

  logic        req_fire;
  logic        rsp_live;
  logic        timeout_hit;
  logic        misalign;

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.instr_out      = instr_out_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.fetch_err      = err_q;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  // A response arriving while drop is set belongs to an abandoned request.
  assign rsp_live = bus.imem_rsp_valid & ~drop_q;
  // This WAIT cycle would be the TIMEOUT_CYCLES-th without a response.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = bus.pc_load && (bus.pc_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    pend_pc_d       = pend_pc_q;
    redirect_pend_d = redirect_pend_q;
    drop_d          = drop_q;
    cnt_d           = cnt_q;
    instr_out_d     = instr_out_q;
    instr_pc_d      = instr_pc_q;
    instr_valid_d   = instr_valid_q;
    err_d           = err_q;

    // The stale response is consumed whatever state we are in.
    if (bus.imem_rsp_valid && drop_q) drop_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.pc_load) begin
          fetch_pc_d = bus.pc_in;
          state_d    = REQ;
        end
      end
      REQ: begin
        // Address must not move before acceptance, so a load is parked as a redirect.
        if (bus.pc_load) begin
          pend_pc_d       = bus.pc_in;
          redirect_pend_d = 1'b1;
        end
        if (req_fire) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (rsp_live) begin
          if (bus.pc_load) begin
            fetch_pc_d      = bus.pc_in;
            redirect_pend_d = 1'b0;
            state_d         = REQ;
          end else if (redirect_pend_q) begin
            fetch_pc_d      = pend_pc_q;
            redirect_pend_d = 1'b0;
            state_d         = REQ;
          end else begin
            instr_out_d   = bus.imem_rsp_data;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (timeout_hit) begin
          // Abandon the request; its response, if it ever comes, is dropped.
          err_d           = 1'b1;
          drop_d          = 1'b1;
          redirect_pend_d = 1'b0;
          if (bus.pc_load) begin
            fetch_pc_d = bus.pc_in;
            state_d    = REQ;
          end else if (redirect_pend_q) begin
            fetch_pc_d = pend_pc_q;
            state_d    = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bus.pc_load) begin
            pend_pc_d       = bus.pc_in;
            redirect_pend_d = 1'b1;
          end
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          if (bus.pc_load) begin
            fetch_pc_d = bus.pc_in;
            state_d    = REQ;
          end else if (redirect_pend_q) begin
            fetch_pc_d      = pend_pc_q;
            redirect_pend_d = 1'b0;
            state_d         = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.pc_load) begin
          // Redirect kills the held instruction.
          instr_valid_d   = 1'b0;
          fetch_pc_d      = bus.pc_in;
          redirect_pend_d = 1'b0;
          state_d         = REQ;
        end
      end
    endcase

    // Misaligned load: flag, kill held/in-flight work, park in IDLE. An unaccepted
    // request is withdrawn; an accepted one has its response dropped.
    if (misalign) begin
      err_d           = 1'b1;
      instr_valid_d   = 1'b0;
      redirect_pend_d = 1'b0;
      state_d         = IDLE;
      if ((state_q == REQ && req_fire) || (state_q == WAIT && !rsp_live)) drop_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= REQ;
      fetch_pc_q      <= RESET_PC;
      pend_pc_q       <= 32'h0;
      redirect_pend_q <= 1'b0;
      drop_q          <= 1'b0;
      cnt_q           <= 8'd0;
      instr_out_q     <= 32'h0;
      instr_pc_q      <= 32'h0;
      instr_valid_q   <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      pend_pc_q       <= pend_pc_d;
      redirect_pend_q <= redirect_pend_d;
      drop_q          <= drop_d;
      cnt_q           <= cnt_d;
      instr_out_q     <= instr_out_d;
      instr_pc_q      <= instr_pc_d;
      instr_valid_q   <= instr_valid_d;
      err_q           <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with TIMEOUT_CYCLES=8.
// Inputs driven and outputs sampled 1ns after each rising edge.
// Memory and decode sides are scripted per test.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  fetch_unit_if u_if ();

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] pc);
    u_if.pc_in   = pc;
    u_if.pc_load = 1'b1;
    tick();
    u_if.pc_load = 1'b0;
  endtask

  // From REQ with ready=1: accept, then return one response -> HOLD.
  task automatic fetch_one(input logic [31:0] data);
    tick();
    u_if.imem_rsp_valid = 1'b1;
    u_if.imem_rsp_data  = data;
    tick();
    u_if.imem_rsp_valid = 1'b0;
  endtask

  task automatic deliver();
    u_if.instr_ready = 1'b1;
    tick();
    u_if.instr_ready = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b0;
    u_if.pc_in          = 32'h0;
    u_if.pc_load        = 1'b0;
    u_if.imem_req_ready = 1'b0;
    u_if.imem_rsp_valid = 1'b0;
    u_if.imem_rsp_data  = 32'h0;
    u_if.instr_ready    = 1'b0;

    // Reset values
    #3;
    chk("rst_instr_valid", 32'(u_if.instr_valid), 32'd0);
    chk("rst_instr_out",   u_if.instr_out, 32'h0);
    chk("rst_instr_pc",    u_if.instr_pc, 32'h0);
    chk("rst_fetch_err",   32'(u_if.fetch_err), 32'd0);

    // Basic fetch from RESET_PC, response two cycles after acceptance
    tick();
    rst = 1'b1;
    u_if.imem_req_ready = 1'b1;
    chk("t1_req_valid", 32'(u_if.imem_req_valid), 32'd1);
    chk("t1_addr",      u_if.imem_addr, 32'h0);
    tick();
    chk("t1_wait_noreq", 32'(u_if.imem_req_valid), 32'd0);
    tick();
    u_if.imem_rsp_valid = 1'b1;
    u_if.imem_rsp_data  = 32'h0000_0013;
    u_if.instr_ready    = 1'b1;
    tick();
    u_if.imem_rsp_valid = 1'b0;
    chk("t1_valid", 32'(u_if.instr_valid), 32'd1);
    chk("t1_out",   u_if.instr_out, 32'h0000_0013);
    chk("t1_pc",    u_if.instr_pc, 32'h0);
    tick();
    u_if.instr_ready = 1'b0;
    chk("t1_done_valid", 32'(u_if.instr_valid), 32'd0);
    chk("t1_idle_noreq", 32'(u_if.imem_req_valid), 32'd0);

    // Request backpressure, then decode backpressure
    u_if.imem_req_ready = 1'b0;
    load(32'h0000_0300);
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_held",  32'(u_if.imem_req_valid), 32'd1);
      chk("t2_addr_held", u_if.imem_addr, 32'h0000_0300);
      tick();
    end
    u_if.imem_req_ready = 1'b1;
    fetch_one(32'hAAAA_0001);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", 32'(u_if.instr_valid), 32'd1);
      chk("t2_hold_out",   u_if.instr_out, 32'hAAAA_0001);
      chk("t2_hold_pc",    u_if.instr_pc, 32'h0000_0300);
      tick();
    end
    deliver();
    chk("t2_done_valid", 32'(u_if.instr_valid), 32'd0);

    // Redirect while waiting: 0x100 data must never be presented
    load(32'h0000_0100);
    tick();
    chk("t3_in_wait", 32'(u_if.imem_req_valid), 32'd0);
    load(32'h0000_0200);
    u_if.imem_rsp_valid = 1'b1;
    u_if.imem_rsp_data  = 32'hDEAD_0100;
    tick();
    u_if.imem_rsp_valid = 1'b0;
    chk("t3_stale_hidden", 32'(u_if.instr_valid), 32'd0);
    chk("t3_req_valid",    32'(u_if.imem_req_valid), 32'd1);
    chk("t3_req_addr",     u_if.imem_addr, 32'h0000_0200);
    fetch_one(32'h0000_2222);
    chk("t3_valid", 32'(u_if.instr_valid), 32'd1);
    chk("t3_out",   u_if.instr_out, 32'h0000_2222);
    chk("t3_pc",    u_if.instr_pc, 32'h0000_0200);
    deliver();

    // Kill of a held instruction
    load(32'h0000_0040);
    fetch_one(32'h0000_4040);
    chk("t4a_held_pc", u_if.instr_pc, 32'h0000_0040);
    load(32'h0000_0080);
    chk("t4a_killed",    32'(u_if.instr_valid), 32'd0);
    chk("t4a_req_valid", 32'(u_if.imem_req_valid), 32'd1);
    chk("t4a_req_addr",  u_if.imem_addr, 32'h0000_0080);
    fetch_one(32'h0000_8080);
    chk("t4a_new_pc",  u_if.instr_pc, 32'h0000_0080);
    chk("t4a_new_out", u_if.instr_out, 32'h0000_8080);
    deliver();

    // Load coincident with handshake: 0x40 delivered, then 0x80 fetched
    load(32'h0000_0040);
    fetch_one(32'h0000_4041);
    u_if.instr_ready = 1'b1;
    chk("t4b_deliver_valid", 32'(u_if.instr_valid), 32'd1);
    chk("t4b_deliver_pc",    u_if.instr_pc, 32'h0000_0040);
    load(32'h0000_0080);
    u_if.instr_ready = 1'b0;
    chk("t4b_after_valid", 32'(u_if.instr_valid), 32'd0);
    chk("t4b_req_valid",   32'(u_if.imem_req_valid), 32'd1);
    chk("t4b_req_addr",    u_if.imem_addr, 32'h0000_0080);
    fetch_one(32'h0000_8081);
    chk("t4b_new_pc", u_if.instr_pc, 32'h0000_0080);
    deliver();

    // Timeout after 8 WAIT cycles, late response ignored
    load(32'h0000_0500);
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t5_no_err_yet", 32'(u_if.fetch_err), 32'd0);
    tick();
    chk("t5_err",    32'(u_if.fetch_err), 32'd1);
    chk("t5_idle",   32'(u_if.imem_req_valid), 32'd0);
    u_if.imem_rsp_valid = 1'b1;
    u_if.imem_rsp_data  = 32'hBAD0_0500;
    tick();
    u_if.imem_rsp_valid = 1'b0;
    chk("t5_late_dropped", 32'(u_if.instr_valid), 32'd0);
    tick();
    chk("t5_still_invalid", 32'(u_if.instr_valid), 32'd0);
    load(32'h0000_0600);
    fetch_one(32'h0000_6666);
    chk("t5_recover_out", u_if.instr_out, 32'h0000_6666);
    chk("t5_err_sticky",  32'(u_if.fetch_err), 32'd1);
    deliver();
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_clear", 32'(u_if.fetch_err), 32'd0);
    chk("t5_async_valid", 32'(u_if.instr_valid), 32'd0);
    tick();
    rst = 1'b1;

    // Leave reset fetch at RESET_PC, then misaligned load
    fetch_one(32'h0000_0001);
    deliver();
    load(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_no_req", 32'(u_if.imem_req_valid), 32'd0);
    chk("t6_err",    32'(u_if.fetch_err), 32'd1);
`else
    chk("t6_req_valid", 32'(u_if.imem_req_valid), 32'd1);
    chk("t6_req_addr",  u_if.imem_addr, 32'h0000_0102);
    chk("t6_no_err",    32'(u_if.fetch_err), 32'd0);
    fetch_one(32'h0000_0102);
    chk("t6_pc", u_if.instr_pc, 32'h0000_0102);
    deliver();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
